// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch controller.
// State encoding, default widths and the request-timer width.
package fetch_pkg;

  localparam int AW_DEF      = 16;
  localparam int DW_DEF      = 16;
  localparam int TW          = 8;
  localparam int TIMEOUT_DEF = 255;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_HOLD  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_HALT  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    FETCH = ST_FETCH,
    HOLD  = ST_HOLD,
    DRAIN = ST_DRAIN,
    HALT  = ST_HALT
  } state_t;

  // A memory request is outstanding in these states.
  function automatic logic is_busy(state_t s);
    return (s == FETCH) || (s == DRAIN);
  endfunction

endpackage

// File: rtl/fetch_timer.sv
// Request watchdog: counts un-acked cycles of the current request.
// tc flags the TIMEOUT-th consecutive un-acked cycle.
module fetch_timer
  import fetch_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [TW-1:0] TERM = TW'(TIMEOUT - 1);

  logic [TW-1:0] count;

  always_ff @(posedge clock) begin
    if (!reset || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + TW'(1);
    end
  end

  // count holds the number of earlier un-acked cycles
  assign tc = en && (count == TERM);

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: one memory read per PC value,
// a one-entry IR toward decode, branch squash and a fetch watchdog.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [AW-1:0] pc,
  input  logic [AW-1:0] pcPlusOne,
  output logic          ce,
  output logic          branchFlag,
  output logic [AW-1:0] dr,
  input  logic          branch_req,
  input  logic [AW-1:0] branch_target,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] ir,
  output logic [AW-1:0] ir_pc_plus_one,
  output logic          ir_valid,
  input  logic          id_ready,
  output logic          fetch_err
);

  state_t        state;
  state_t        state_n;
  logic          req_n;
  logic [AW-1:0] addr_n;
  logic [DW-1:0] ir_n;
  logic [AW-1:0] irp1_n;
  logic          irv_n;
  logic          err_n;
  logic          ce_c;
  logic          bf_c;
  logic          t_clr;
  logic          t_en;
  logic          t_tc;

  fetch_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clock(clock),
    .reset(reset),
    .clr  (t_clr),
    .en   (t_en),
    .tc   (t_tc)
  );

  assign t_en = is_busy(state) && !mem_ack;

  always_comb begin
    state_n = state;
    req_n   = mem_req;
    addr_n  = mem_addr;
    ir_n    = ir;
    irp1_n  = ir_pc_plus_one;
    irv_n   = ir_valid;
    err_n   = fetch_err;
    ce_c    = 1'b0;
    bf_c    = 1'b0;
    t_clr   = 1'b0;
    unique case (state)
      IDLE: begin
        if (branch_req) begin
          ce_c = 1'b1;
          bf_c = 1'b1;
        end else begin
          req_n   = 1'b1;
          addr_n  = pc;
          t_clr   = 1'b1;
          state_n = FETCH;
        end
      end
      FETCH: begin
        if (branch_req) begin
          ce_c = 1'b1;
          bf_c = 1'b1;
          if (mem_ack) begin
            req_n   = 1'b0;
            state_n = IDLE;
          end else if (t_tc) begin
            req_n   = 1'b0;
            err_n   = 1'b1;
            state_n = HALT;
          end else begin
            state_n = DRAIN;
          end
        end else if (mem_ack) begin
          ir_n    = mem_rdata;
          irp1_n  = pcPlusOne;
          irv_n   = 1'b1;
          req_n   = 1'b0;
          ce_c    = 1'b1;
          state_n = HOLD;
        end else if (t_tc) begin
          req_n   = 1'b0;
          err_n   = 1'b1;
          state_n = HALT;
        end
      end
      HOLD: begin
        if (branch_req) begin
          irv_n   = 1'b0;
          ce_c    = 1'b1;
          bf_c    = 1'b1;
          state_n = IDLE;
        end else if (id_ready) begin
          irv_n   = 1'b0;
          req_n   = 1'b1;
          addr_n  = pc;
          t_clr   = 1'b1;
          state_n = FETCH;
        end
      end
      DRAIN: begin
        // wrong-path request stays up until memory answers it
        if (branch_req) begin
          ce_c = 1'b1;
          bf_c = 1'b1;
        end
        if (mem_ack) begin
          req_n   = 1'b0;
          state_n = IDLE;
        end else if (t_tc) begin
          req_n   = 1'b0;
          err_n   = 1'b1;
          state_n = HALT;
        end
      end
      HALT: begin
        req_n = 1'b0;
      end
      default: begin
        req_n   = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state          <= IDLE;
      mem_req        <= 1'b0;
      mem_addr       <= '0;
      ir             <= '0;
      ir_pc_plus_one <= '0;
      ir_valid       <= 1'b0;
      fetch_err      <= 1'b0;
    end else begin
      state          <= state_n;
      mem_req        <= req_n;
      mem_addr       <= addr_n;
      ir             <= ir_n;
      ir_pc_plus_one <= irp1_n;
      ir_valid       <= irv_n;
      fetch_err      <= err_n;
    end
  end

  assign ce         = reset && ce_c;
  assign branchFlag = reset && bf_c;
  assign dr         = branch_target;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: acts as program counter and memory,
// checks against a transaction-level fetch model.
module tb_fetch_ctrl;

  localparam int TMO = 255;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] pc = '0;
  logic [15:0] pcPlusOne = 16'd1;
  logic        ce;
  logic        branchFlag;
  logic [15:0] dr;
  logic        branch_req = 1'b0;
  logic [15:0] branch_target = '0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic [15:0] ir;
  logic [15:0] ir_pc_plus_one;
  logic        ir_valid;
  logic        id_ready = 1'b0;
  logic        fetch_err;

  int n_cmp = 0;
  int n_bad = 0;

  // program counter owned by the bench
  logic [15:0] bpc = '0;

  // fetch model: outstanding request, IR slot, flow target
  logic        m_req;
  logic [15:0] m_addr;
  logic        m_sq;
  logic        m_irv;
  logic [15:0] m_ir;
  logic [15:0] m_irp1;
  logic        m_halt;
  logic        m_err;
  logic [15:0] exp_next;
  int          m_wait;

  logic resp_busy = 1'b0;
  int   lat = 0;

  always #5 clock = ~clock;

  fetch_ctrl dut (
    .clock         (clock),
    .reset         (reset),
    .pc            (pc),
    .pcPlusOne     (pcPlusOne),
    .ce            (ce),
    .branchFlag    (branchFlag),
    .dr            (dr),
    .branch_req    (branch_req),
    .branch_target (branch_target),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .ir            (ir),
    .ir_pc_plus_one(ir_pc_plus_one),
    .ir_valid      (ir_valid),
    .id_ready      (id_ready),
    .fetch_err     (fetch_err)
  );

  task automatic chk16(input string tag, input logic [15:0] obs,
                       input logic [15:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_req    = 1'b0;
    m_addr   = '0;
    m_sq     = 1'b0;
    m_irv    = 1'b0;
    m_ir     = '0;
    m_irp1   = '0;
    m_halt   = 1'b0;
    m_err    = 1'b0;
    exp_next = '0;
    m_wait   = 0;
    bpc      = '0;
    resp_busy = 1'b0;
  endtask

  task automatic post_chk();
    chk1("mem_req", mem_req, m_req);
    if (m_req) chk16("mem_addr", mem_addr, m_addr);
    chk1("ir_valid", ir_valid, m_irv);
    chk16("ir", ir, m_ir);
    chk16("ir_pc_plus_one", ir_pc_plus_one, m_irp1);
    chk1("fetch_err", fetch_err, m_err);
  endtask

  // one clock cycle; entered and left at posedge+1
  task automatic cyc(input logic br, input logic [15:0] bt,
                     input logic ack, input logic rdy,
                     input logic [15:0] rd);
    logic        acc;
    logic        dlv;
    logic        issue;
    logic        tmo;
    logic [15:0] bpc_n;
    reset         = 1'b1;
    branch_req    = br;
    branch_target = bt;
    mem_ack       = ack;
    id_ready      = rdy;
    mem_rdata     = rd;
    pc            = bpc;
    pcPlusOne     = bpc + 16'd1;
    #2;
    acc   = m_req && ack;
    dlv   = acc && !br && !m_sq;
    issue = !m_halt && !m_req && !br && (!m_irv || rdy);
    tmo   = m_req && !ack && (m_wait == TMO - 1);
    chk1("ce", ce, !m_halt && (br || dlv));
    chk1("branchFlag", branchFlag, !m_halt && br);
    chk16("dr", dr, bt);
    bpc_n = !ce ? bpc : (branchFlag ? dr : bpc + 16'd1);
    if (!m_halt) begin
      if (dlv) begin
        m_irv    = 1'b1;
        m_ir     = rd;
        m_irp1   = m_addr + 16'd1;
        exp_next = m_addr + 16'd1;
      end else if (m_irv && (rdy || br)) begin
        m_irv = 1'b0;
      end
      if (br) begin
        exp_next = bt;
        if (m_req && !ack) m_sq = 1'b1;
      end
      if (tmo) begin
        m_halt = 1'b1;
        m_err  = 1'b1;
        m_req  = 1'b0;
      end else if (acc) begin
        m_req = 1'b0;
      end else if (m_req) begin
        m_wait++;
      end
      if (issue) begin
        m_req  = 1'b1;
        m_addr = exp_next;
        m_sq   = 1'b0;
        m_wait = 0;
      end
    end
    @(posedge clock);
    #1;
    bpc = bpc_n;
    post_chk();
  endtask

  task automatic rst(input int n);
    for (int i = 0; i < n; i++) begin
      reset         = 1'b0;
      branch_req    = 1'($urandom_range(0, 1));
      branch_target = 16'($urandom);
      mem_ack       = 1'($urandom_range(0, 1));
      id_ready      = 1'($urandom_range(0, 1));
      mem_rdata     = 16'($urandom);
      #2;
      chk1("rst_ce", ce, 1'b0);
      chk1("rst_branchFlag", branchFlag, 1'b0);
      @(posedge clock);
      #1;
      chk1("rst_mem_req", mem_req, 1'b0);
      chk16("rst_mem_addr", mem_addr, 16'h0000);
      chk16("rst_ir", ir, 16'h0000);
      chk16("rst_ir_pc_plus_one", ir_pc_plus_one, 16'h0000);
      chk1("rst_ir_valid", ir_valid, 1'b0);
      chk1("rst_fetch_err", fetch_err, 1'b0);
    end
    model_reset();
  endtask

  task automatic rand_cyc();
    logic a;
    a = 1'b0;
    if (mem_req) begin
      if (!resp_busy) begin
        resp_busy = 1'b1;
        lat = $urandom_range(0, 4);
      end
      if (lat == 0) begin
        a = 1'b1;
        resp_busy = 1'b0;
      end else begin
        lat--;
      end
    end else begin
      a = ($urandom_range(0, 15) == 0);
    end
    cyc($urandom_range(0, 9) == 0, 16'($urandom), a,
        1'($urandom_range(0, 1)), 16'($urandom));
  endtask

  initial begin
    model_reset();
    @(posedge clock);
    #1;
    rst(2);

    // first fetch from pc 0, ack two cycles after issue
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    chk1("d1_req", mem_req, 1'b1);
    chk16("d1_addr", mem_addr, 16'h0000);
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    cyc(1'b0, 16'h0, 1'b1, 1'b0, 16'hA5A5);
    chk16("d1_ir", ir, 16'hA5A5);
    chk16("d1_irp1", ir_pc_plus_one, 16'h0001);
    chk1("d1_irv", ir_valid, 1'b1);

    // decode stalls, then consumes
    repeat (5) cyc(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    chk1("d2_noreq", mem_req, 1'b0);
    chk16("d2_ir", ir, 16'hA5A5);
    cyc(1'b0, 16'h0, 1'b0, 1'b1, 16'h0);
    chk1("d2_irv", ir_valid, 1'b0);
    chk1("d2_req", mem_req, 1'b1);
    chk16("d2_addr", mem_addr, 16'h0001);

    // branch while fetching, late ack is dropped
    cyc(1'b1, 16'h0040, 1'b0, 1'b0, 16'h0);
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    cyc(1'b0, 16'h0, 1'b1, 1'b0, 16'hDEAD);
    chk1("d3_irv", ir_valid, 1'b0);
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    chk16("d3_addr", mem_addr, 16'h0040);

    // branch and ack in the same cycle
    cyc(1'b1, 16'h0080, 1'b1, 1'b0, 16'hBEEF);
    chk16("d4_ir", ir, 16'hA5A5);
    chk1("d4_irv", ir_valid, 1'b0);
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    chk16("d4_addr", mem_addr, 16'h0080);

    // branch while IR is held and decode is ready
    cyc(1'b0, 16'h0, 1'b1, 1'b0, 16'h1234);
    chk16("d5_irp1", ir_pc_plus_one, 16'h0081);
    cyc(1'b1, 16'h0100, 1'b0, 1'b1, 16'h0);
    chk1("d5_irv", ir_valid, 1'b0);
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    chk16("d5_addr", mem_addr, 16'h0100);

    // ack on the last cycle before timeout
    repeat (TMO - 1) cyc(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    cyc(1'b0, 16'h0, 1'b1, 1'b0, 16'h5A5A);
    chk1("late_err", fetch_err, 1'b0);
    chk16("late_ir", ir, 16'h5A5A);

    // no ack at all: timeout, halt, recover through reset
    cyc(1'b0, 16'h0, 1'b0, 1'b1, 16'h0);
    repeat (TMO) cyc(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    chk1("tmo_err", fetch_err, 1'b1);
    chk1("tmo_req", mem_req, 1'b0);
    repeat (4) cyc(1'b1, 16'($urandom), 1'b1, 1'b1, 16'($urandom));
    rst(1);
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    chk16("rec_addr", mem_addr, 16'h0000);
    chk1("rec_req", mem_req, 1'b1);

    // random traffic with a reset in the middle
    for (int k = 0; k < 3000; k++) begin
      if (k == 1500) rst(1);
      rand_cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
